fmpadding_cfg_axi: RTL and testbench
====================================

Name: fmpadding_cfg_axi

Overview:
- Run-time configurable feature-map padder for SIMD-folded AXI-Stream activations.
- Generalises the existing padder with:
  - a programmable pad element value;
  - shadowed configuration registers, applied only on a frame boundary;
  - TLAST generation on the last output beat of each frame;
  - frame-done and busy status.
- Sits between a stream producer and a sliding-window generator in the dataflow pipeline.

Parameters:
- XCOUNTER_BITS, 8, width of X counter and X config registers
- YCOUNTER_BITS, 8, width of Y counter and Y config registers
- NUM_CHANNELS, 4, channel count; must be a positive multiple of SIMD (elaboration $error otherwise)
- SIMD, 2, elements per beat
- ELEM_BITS, 8, bits per element
- STREAM_BITS, derived, 8*ceil(SIMD*ELEM_BITS/8); localparam

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- we  in  1  config write strobe
- wa  in  3  config write address
- wd  in  32  config write data
- s_axis_tready  out  1  input ready
- s_axis_tvalid  in  1  input valid
- s_axis_tdata  in  STREAM_BITS  input beat
- m_axis_tready  in  1  output ready
- m_axis_tvalid  out  1  output valid
- m_axis_tdata  out  STREAM_BITS  output beat
- m_axis_tlast  out  1  last beat of frame
- frame_done  out  1  one-cycle pulse when last beat of a frame is accepted downstream
- busy  out  1  frame in progress (at least one beat of current frame generated)

Behaviour:
- Reset:
  - One clock domain; reset is asynchronous and active-low (ap_rst_n).
  - All registers clear, including shadow and active config, counters, buffers A/B, commit_pend and started.
  - Outputs after reset: m_axis_tvalid=0, m_axis_tlast=0, frame_done=0, busy=0, s_axis_tready=1.
- Config map:
  - Writes go to shadow registers, truncated to the register width.
  - 0 XOn, 1 XOff, 2 XEnd, 3 PadVal[ELEM_BITS-1:0], 4 YOn, 5 YOff, 6 YEnd.
  - 7: writing wd[0]=1 sets commit_pend.
  - Writes to address 7 with wd[0]=0 are ignored. No $stop.
- Commit:
  - Shadow copies to active and commit_pend clears on either of two edges:
    - a clock edge with commit_pend=1 and started=0;
    - the edge that generates the last beat of a frame.
  - Same-cycle we to address 7 during a commit edge: the new request stays pending.
  - Same-cycle shadow write during a commit edge: the write lands in shadow only.
  - Active config never changes mid-frame.
- Counters (all use active config):
  - SCount counts SF-2 down to -1, where SF=NUM_CHANNELS/SIMD. Its MSB marks the end of the channel fold.
  - XCount runs 0..XEnd and YCount runs 0..YEnd, cascaded.
  - Enable sen = (m_axis_tready || !B.vld) && (s_axis_tvalid || A.vld || !fwd).
  - fwd = (XOn<=XCount<XOff) && (YOn<=YCount<YOff).
- Datapath, two-slot skid buffer:
  - s_axis_tready = !A.vld.
  - B loads when (m_axis_tready || !B.vld).
  - B.dat = fwd ? (A.vld ? A.dat : s_axis_tdata) : {SIMD{PadVal}}, zero-extended to STREAM_BITS.
  - A captures input when input is accepted but B cannot take it, or when the current position pads.
  - Latency is 1 cycle from input accept to m_axis_tvalid when B is empty. Throughput is 1 beat/cycle.
- TLAST:
  - B.last is stored with B.dat.
  - It is 1 when the beat is generated at SCount end && XCount==XEnd && YCount==YEnd.
  - m_axis_tlast = B.vld && B.last.
- Status:
  - frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast, registered to a 1-cycle pulse.
  - busy=started; it sets on the first generated beat of a frame and clears on the last.
- Boundary conditions:
  - XOn>=XOff or YOn>=YOff: whole frame padded, no input consumed. Legal.
  - Backpressure (m_axis_tready=0): B holds data and last. At most one input beat is absorbed into A, then s_axis_tready=0.
  - Counter wrap is exclusively via the End compare; XEnd=0 gives 1 column.
  - Asynchronous reset mid-frame: immediate clear; any pending commit is lost.
- Configuration errors: input beat count must equal the forwarded positions per frame; a mismatch is not detected.

Test Plan:
- Default 4x4 frame, NUM_CHANNELS=4, SIMD=2, 1-pixel border:
  - Config: XOn=1, XOff=3, XEnd=3, YOn=1, YOff=3, YEnd=3, PadVal=0, commit.
  - Stimulus: 8 input beats.
  - Required response: 32 output beats; interior beats equal the inputs in order; tlast only on beat 32; single frame_done.
- PadVal=8'hA5, same geometry: every pad beat = 16'hA5A5; interior beats unchanged.
- Mid-frame reconfiguration:
  - After output beat 10, write XEnd=5 and commit.
  - Required response: the current frame still ends at beat 32. The next frame uses the 6-column width: 48 beats, tlast on beat 48.
- Random m_axis_tready (50%) and random s_axis_tvalid: output sequence is identical to the no-stall case; no beat is lost or duplicated; s_axis_tready never asserts while A.vld=1.
- All-pad config XOn=XOff=0:
  - Required response: 32 PadVal beats with s_axis_tready held 1 and no input consumed; tlast on the 32nd beat.
- Reset mid-frame:
  - Drop ap_rst_n at beat 7.
  - Required response: outputs go to reset values immediately; busy=0; active config=0; a fresh config plus commit restarts a clean frame.

Source files
------------

// File: rtl/fmpadding_cfg_axi.sv
// fmpadding_cfg_axi: run-time configurable feature-map padder for SIMD-folded AXI-Stream activations,
// with shadowed config committed on frame boundaries, TLAST generation and frame status.
module fmpadding_cfg_axi #(
    parameter int XCOUNTER_BITS = 8,
    parameter int YCOUNTER_BITS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int SIMD          = 2,
    parameter int ELEM_BITS     = 8,
    localparam int STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   we,
    input  logic [2:0]             wa,
    input  logic [31:0]            wd,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tvalid,
    input  logic [STREAM_BITS-1:0] s_axis_tdata,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [STREAM_BITS-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   frame_done,
    output logic                   busy
);
    localparam int SF = NUM_CHANNELS / SIMD;
    localparam int SB = $clog2(SF + 1) + 1;
    localparam logic [SB-1:0] S_INIT = SB'(SF - 2);

    if (NUM_CHANNELS < SIMD || NUM_CHANNELS % SIMD != 0) begin : g_bad_fold
        $error("NUM_CHANNELS must be a positive multiple of SIMD");
    end

    logic [XCOUNTER_BITS-1:0] xon_s, xoff_s, xend_s, xon, xoff, xend, xcnt;
    logic [YCOUNTER_BITS-1:0] yon_s, yoff_s, yend_s, yon, yoff, yend, ycnt;
    logic [ELEM_BITS-1:0]     pad_s, pad;
    logic [SB-1:0]            scnt;
    logic                     commit_pend, started;
    logic                     a_vld, b_vld, b_last;
    logic [STREAM_BITS-1:0]   a_dat, b_dat, pad_beat;
    logic                     fwd, b_ld, sen, in_acc, last_gen, commit;
    logic                     unused_wd;

    assign unused_wd     = ^wd;
    assign fwd           = xcnt >= xon && xcnt < xoff && ycnt >= yon && ycnt < yoff;
    assign b_ld          = m_axis_tready || !b_vld;
    assign sen           = b_ld && (s_axis_tvalid || a_vld || !fwd);
    assign in_acc        = s_axis_tvalid && !a_vld;
    assign last_gen      = scnt[SB-1] && xcnt == xend && ycnt == yend;
    // Active config only moves while idle or on the edge that closes a frame.
    assign commit        = commit_pend && (!started || (sen && last_gen));
    assign pad_beat      = STREAM_BITS'({SIMD{pad}});
    assign s_axis_tready = !a_vld;
    assign m_axis_tvalid = b_vld;
    assign m_axis_tdata  = b_dat;
    assign m_axis_tlast  = b_vld && b_last;
    assign busy          = started;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            xon_s       <= '0;
            xoff_s      <= '0;
            xend_s      <= '0;
            pad_s       <= '0;
            yon_s       <= '0;
            yoff_s      <= '0;
            yend_s      <= '0;
            xon         <= '0;
            xoff        <= '0;
            xend        <= '0;
            pad         <= '0;
            yon         <= '0;
            yoff        <= '0;
            yend        <= '0;
            commit_pend <= 1'b0;
        end else begin
            if (we) begin
                case (wa)
                    3'd0:    xon_s  <= wd[XCOUNTER_BITS-1:0];
                    3'd1:    xoff_s <= wd[XCOUNTER_BITS-1:0];
                    3'd2:    xend_s <= wd[XCOUNTER_BITS-1:0];
                    3'd3:    pad_s  <= wd[ELEM_BITS-1:0];
                    3'd4:    yon_s  <= wd[YCOUNTER_BITS-1:0];
                    3'd5:    yoff_s <= wd[YCOUNTER_BITS-1:0];
                    3'd6:    yend_s <= wd[YCOUNTER_BITS-1:0];
                    default: ;
                endcase
            end
            // A fresh request arriving on a commit edge survives for the next boundary.
            commit_pend <= (we && wa == 3'd7 && wd[0]) || (commit_pend && !commit);
            if (commit) begin
                xon  <= xon_s;
                xoff <= xoff_s;
                xend <= xend_s;
                pad  <= pad_s;
                yon  <= yon_s;
                yoff <= yoff_s;
                yend <= yend_s;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            scnt    <= S_INIT;
            xcnt    <= '0;
            ycnt    <= '0;
            started <= 1'b0;
        end else if (sen) begin
            started <= !last_gen;
            if (scnt[SB-1]) begin
                scnt <= S_INIT;
                if (xcnt == xend) begin
                    xcnt <= '0;
                    ycnt <= ycnt == yend ? '0 : ycnt + 1'b1;
                end else begin
                    xcnt <= xcnt + 1'b1;
                end
            end else begin
                scnt <= scnt - 1'b1;
            end
        end
    end

    // Slot A parks an accepted beat that B cannot take this cycle (stall or pad position).
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_vld      <= 1'b0;
            a_dat      <= '0;
            b_vld      <= 1'b0;
            b_dat      <= '0;
            b_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (in_acc && !(b_ld && fwd)) begin
                a_vld <= 1'b1;
                a_dat <= s_axis_tdata;
            end else if (sen && fwd) begin
                a_vld <= 1'b0;
            end
            if (b_ld)
                b_vld <= sen;
            if (sen) begin
                b_dat  <= fwd ? (a_vld ? a_dat : s_axis_tdata) : pad_beat;
                b_last <= last_gen;
            end
            frame_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
        end
    end
endmodule

// File: tb/tb_fmpadding_cfg_axi.sv
// tb_fmpadding_cfg_axi: randomized bench comparing the padder's output stream against
// a frame-level reference built from the padding rules.
module tb_fmpadding_cfg_axi;
    localparam int SIMD = 2;
    localparam int SF   = 2;
    localparam int SW   = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          we = 1'b0;
    logic [2:0]    wa = '0;
    logic [31:0]   wd = '0;
    logic          s_axis_tready;
    logic          s_axis_tvalid = 1'b0;
    logic [SW-1:0] s_axis_tdata = '0;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tvalid;
    logic [SW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          frame_done;
    logic          busy;

    int n_assert = 0;
    int n_fail = 0;
    logic [SW:0]   exp_q[$];
    logic [SW-1:0] in_q[$];

    always #5 ap_clk = ~ap_clk;

    fmpadding_cfg_axi dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .we(we),
        .wa(wa),
        .wd(wd),
        .s_axis_tready(s_axis_tready),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata(s_axis_tdata),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, req);
        end
    endtask

    // One frame in raster order: y outer, x, then channel fold; pad positions carry {SIMD{pad}}.
    task automatic gen_frame(input int xon, input int xoff, input int xend, input int yon,
                             input int yoff, input int yend, input logic [7:0] pad);
        logic [SW-1:0] d;
        for (int y = 0; y <= yend; y++)
            for (int x = 0; x <= xend; x++)
                for (int s = 0; s < SF; s++) begin
                    if (x >= xon && x < xoff && y >= yon && y < yoff) begin
                        d = SW'($urandom);
                        in_q.push_back(d);
                    end else begin
                        d = {SIMD{pad}};
                    end
                    exp_q.push_back({y == yend && x == xend && s == SF - 1, d});
                end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge ap_clk);
        we = 1'b1;
        wa = a;
        wd = a == 3'd7 ? d : {24'($urandom), d[7:0]};
        @(negedge ap_clk);
        we = 1'b0;
    endtask

    task automatic cfg(input int xon, input int xoff, input int xend, input int yon,
                       input int yoff, input int yend, input logic [7:0] pad);
        wr(3'd0, 32'(xon));
        wr(3'd1, 32'(xoff));
        wr(3'd2, 32'(xend));
        wr(3'd3, {24'd0, pad});
        wr(3'd4, 32'(yon));
        wr(3'd5, 32'(yoff));
        wr(3'd6, 32'(yend));
        wr(3'd7, 32'h0000_0002);
        wr(3'd7, 32'h0000_0001);
    endtask

    task automatic reset_dut();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        we = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        exp_q.delete();
        in_q.delete();
        @(negedge ap_clk);
        chk("rst tvalid", m_axis_tvalid, 0);
        chk("rst tlast", m_axis_tlast, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst busy", busy, 0);
        chk("rst s_tready", s_axis_tready, 1);
        ap_rst_n = 1'b1;
    endtask

    // Consume expected beats with the given ready probability; stops after max_beats or when drained.
    task automatic run(input int max_beats, input int p_ready, input bit rnd_valid, input bit chk_sready);
        int cyc = 0;
        int got = 0;
        int fd_seen = 0;
        int lasts = 0;
        logic [SW:0] e;
        forever begin
            @(negedge ap_clk);
            if (frame_done) fd_seen++;
            if (chk_sready) chk("s_tready held", s_axis_tready, 1);
            if (exp_q.size() == 0 || got == max_beats) break;
            if (++cyc > 5000) begin
                chk("output timeout", exp_q.size(), 0);
                break;
            end
            m_axis_tready = $urandom_range(99) < p_ready;
            s_axis_tvalid = in_q.size() > 0 && (!rnd_valid || $urandom_range(1) == 1);
            s_axis_tdata = in_q.size() > 0 ? in_q[0] : '0;
            if (m_axis_tvalid && m_axis_tready) begin
                e = exp_q.pop_front();
                chk("beat data", m_axis_tdata, e[SW-1:0]);
                chk("beat tlast", m_axis_tlast, e[SW]);
                if (e[SW]) lasts++;
                got++;
            end
            if (s_axis_tvalid && s_axis_tready) void'(in_q.pop_front());
        end
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("frame_done pulses", fd_seen, lasts);
    endtask

    initial begin
        // Reset config is all zero: a 1-pixel pad frame is already in flight when the commit lands.
        reset_dut();
        cfg(1, 3, 3, 1, 3, 3, 8'h00);
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        gen_frame(1, 3, 3, 1, 3, 3, 8'h00);
        run(1000, 100, 1'b0, 1'b0);
        chk("inputs consumed", in_q.size(), 0);

        reset_dut();
        cfg(1, 3, 3, 1, 3, 3, 8'hA5);
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        gen_frame(1, 3, 3, 1, 3, 3, 8'hA5);
        run(1000, 50, 1'b1, 1'b0);
        chk("inputs consumed A5", in_q.size(), 0);

        reset_dut();
        cfg(1, 3, 3, 1, 3, 3, 8'h3C);
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        gen_frame(1, 3, 3, 1, 3, 3, 8'h3C);
        gen_frame(1, 3, 5, 1, 3, 3, 8'h3C);
        run(SF + 10, 100, 1'b0, 1'b0);
        chk("busy mid-frame", busy, 1);
        wr(3'd2, 32'd5);
        wr(3'd7, 32'd1);
        run(1000, 50, 1'b1, 1'b0);
        chk("inputs consumed reconfig", in_q.size(), 0);

        reset_dut();
        cfg(0, 0, 3, 1, 3, 3, 8'h5A);
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        gen_frame(0, 0, 3, 1, 3, 3, 8'h5A);
        run(1000, 50, 1'b0, 1'b1);

        reset_dut();
        cfg(0, 1, 0, 1, 2, 2, 8'h77);
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        gen_frame(0, 1, 0, 1, 2, 2, 8'h77);
        run(1000, 70, 1'b1, 1'b0);
        chk("inputs consumed xend0", in_q.size(), 0);

        reset_dut();
        cfg(1, 3, 3, 1, 3, 3, 8'h11);
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        gen_frame(1, 3, 3, 1, 3, 3, 8'h11);
        run(SF + 7, 100, 1'b0, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        chk("async rst tvalid", m_axis_tvalid, 0);
        chk("async rst tlast", m_axis_tlast, 0);
        chk("async rst frame_done", frame_done, 0);
        chk("async rst busy", busy, 0);
        chk("async rst s_tready", s_axis_tready, 1);
        exp_q.delete();
        in_q.delete();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        run(1000, 100, 1'b0, 1'b0);
        cfg(1, 3, 3, 1, 3, 3, 8'h22);
        gen_frame(0, 0, 0, 0, 0, 0, 8'h00);
        gen_frame(1, 3, 3, 1, 3, 3, 8'h22);
        run(1000, 50, 1'b1, 1'b0);
        chk("inputs consumed restart", in_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
